// File: rtl/jk_updown_counter_pkg.sv
// Shared JK mode encodings and the load-clamp helper for jk_updown_counter.
`timescale 1ns/1ps
package jk_updown_counter_pkg;

  // Encoded as {J,K}.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_mode_e;

  localparam int MAX_W = 16;

  // Out-of-range load values clamp to the top count (modulus-1).
  function automatic logic [MAX_W:0] clamp_load(input logic [MAX_W:0] d,
                                                input logic [MAX_W:0] modulus);
    return (d >= modulus) ? (modulus - 17'd1) : d;
  endfunction

endpackage

// File: rtl/jk_updown_counter_jk_ff_cell.sv
// One-bit JK flip-flop cell with asynchronous active-low reset to 0.
`timescale 1ns/1ps
module jk_ff_cell
  import jk_updown_counter_pkg::*;
(
  input  logic J,
  input  logic K,
  input  logic CLK,
  input  logic RESET_N,
  output logic Q
);

  jk_mode_e w_mode;
  logic     r_q;

  assign w_mode = jk_mode_e'({J, K});
  assign Q      = r_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_q <= 1'b0;
    end else begin
      case (w_mode)
        JK_HOLD: r_q <= r_q;
        JK_RST:  r_q <= 1'b0;
        JK_SET:  r_q <= 1'b1;
        JK_TGL:  r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MOD up/down counter built from JK cells, with terminal count and wrap pulse.
// Build macro JK_CNT_SATURATE_EN: saturate at the ends instead of wrapping (WRAP stays 0).
`timescale 1ns/1ps
module jk_updown_counter
  import jk_updown_counter_pkg::*;
#(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         EN,
  input  logic         UP,
  input  logic         LOAD,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic         TC,
  output logic         WRAP
);

  localparam logic [W-1:0] MAX_Q = W'(MOD - 1);

  wire  [W-1:0] w_q;
  wire  [W-1:0] w_j;
  wire  [W-1:0] w_k;
  logic [W-1:0] w_qn;
  logic [W-1:0] w_load_val;
  logic         w_force;
  logic         w_wrap_evt;
  logic         r_wrap;

  assign w_load_val = W'(clamp_load(17'(D), 17'(MOD)));

  always_comb begin
    w_qn       = w_q;
    w_force    = 1'b0;
    w_wrap_evt = 1'b0;
    if (LOAD) begin
      w_qn    = w_load_val;
      w_force = 1'b1;
    end else if (EN) begin
      if (UP) begin
        if (w_q == MAX_Q) begin
`ifdef JK_CNT_SATURATE_EN
          w_qn = w_q;
`else
          w_qn       = '0;
          w_force    = 1'b1;
          w_wrap_evt = 1'b1;
`endif
        end else begin
          w_qn = w_q + W'(1);
        end
      end else begin
        if (w_q == '0) begin
`ifdef JK_CNT_SATURATE_EN
          w_qn = w_q;
`else
          w_qn       = MAX_Q;
          w_force    = 1'b1;
          w_wrap_evt = 1'b1;
`endif
        end else begin
          w_qn = w_q - W'(1);
        end
      end
    end
  end

  // Normal steps toggle only the changing bits; wraps and loads set/reset every cell.
  for (genvar i = 0; i < W; i++) begin : g_cell
    assign w_j[i] = w_force ? w_qn[i]  : (w_qn[i] ^ w_q[i]);
    assign w_k[i] = w_force ? ~w_qn[i] : (w_qn[i] ^ w_q[i]);
    jk_ff_cell u_cell (
      .J      (w_j[i]),
      .K      (w_k[i]),
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .Q      (w_q[i])
    );
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_evt;
    end
  end

  assign Q    = w_q;
  assign TC   = UP ? (w_q == MAX_Q) : (w_q == '0);
  assign WRAP = r_wrap;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Bench for jk_updown_counter (W=4, MOD=10) against an arithmetic reference model.
`timescale 1ns/1ps
module tb_jk_updown_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         CLK;
  logic         RESET_N;
  logic         EN;
  logic         UP;
  logic         LOAD;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         TC;
  logic         WRAP;

  int tests_run    = 0;
  int tests_failed = 0;

  int m_q    = 0;
  int m_wrap = 0;

  jk_updown_counter #(.W(W), .MOD(MOD)) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .EN     (EN),
    .UP     (UP),
    .LOAD   (LOAD),
    .D      (D),
    .Q      (Q),
    .TC     (TC),
    .WRAP   (WRAP)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #2 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  // Reference model: modulo arithmetic on the count.
  function automatic void model_step(input logic en, input logic up, input logic load,
                                     input int d);
    if (load) begin
      m_q    = (d >= MOD) ? MOD - 1 : d;
      m_wrap = 0;
    end else if (en) begin
      int nxt;
      int wrapped;
      nxt     = up ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
      wrapped = up ? (m_q == MOD - 1) : (m_q == 0);
`ifdef JK_CNT_SATURATE_EN
      if (wrapped) nxt = m_q;
      m_wrap = 0;
`else
      m_wrap = wrapped;
`endif
      m_q = nxt;
    end else begin
      m_wrap = 0;
    end
  endfunction

  function automatic int model_tc();
    return UP ? int'(m_q == MOD - 1) : int'(m_q == 0);
  endfunction

  // Driver: apply inputs, take one edge, advance the model, settle 1 ns.
  task automatic cycle(input logic en, input logic up, input logic load, input logic [W-1:0] d);
    EN   = en;
    UP   = up;
    LOAD = load;
    D    = d;
    @(posedge CLK);
    model_step(en, up, load, int'(d));
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b1; EN = 1'b0; UP = 1'b0; LOAD = 1'b0; D = '0;
    #1;
    RESET_N = 1'b0;
    #0.5;
    m_q = 0; m_wrap = 0;
    tests_run++;
    if (Q !== 4'd0) begin tests_failed++; $display("FAIL reset_q: got %0d expected 0", Q); end
    tests_run++;
    if (WRAP !== 1'b0) begin tests_failed++; $display("FAIL reset_wrap: got %b expected 0", WRAP); end
    tests_run++;
    if (TC !== 1'b1) begin tests_failed++; $display("FAIL reset_tc_down: got %b expected 1", TC); end
    UP = 1'b1;
    #0.1;
    tests_run++;
    if (TC !== 1'b0) begin tests_failed++; $display("FAIL reset_tc_up: got %b expected 0", TC); end
    @(negedge CLK);
    RESET_N = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, '0);
    tests_run++;
    if (Q !== 4'd0) begin tests_failed++; $display("FAIL release_hold_q: got %0d expected 0", Q); end
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      tests_run++;
      if (Q !== 4'(m_q) || WRAP !== 1'(m_wrap) || TC !== 1'(model_tc())) begin
        tests_failed++;
        $display("FAIL count_up[%0d]: got q=%0d wrap=%b tc=%b expected q=%0d wrap=%0d tc=%0d",
                 i, Q, WRAP, TC, m_q, m_wrap, model_tc());
      end
    end
  endtask

  task automatic test_count_down();
    cycle(1'b0, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      tests_run++;
      if (Q !== 4'(m_q) || WRAP !== 1'(m_wrap) || TC !== 1'(model_tc())) begin
        tests_failed++;
        $display("FAIL count_down[%0d]: got q=%0d wrap=%b tc=%b expected q=%0d wrap=%0d tc=%0d",
                 i, Q, WRAP, TC, m_q, m_wrap, model_tc());
      end
    end
  endtask

  task automatic test_load_clamp();
    cycle(1'b1, 1'b1, 1'b1, 4'd13);
    tests_run++;
    if (Q !== 4'd9 || WRAP !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_clamp: got q=%0d wrap=%b expected q=9 wrap=0", Q, WRAP);
    end
    cycle(1'b0, 1'b1, 1'b1, 4'd5);
    tests_run++;
    if (Q !== 4'd5) begin tests_failed++; $display("FAIL load_5: got %0d expected 5", Q); end
    cycle(1'b1, 1'b0, 1'b1, 4'd15);
    tests_run++;
    if (Q !== 4'(m_q)) begin tests_failed++; $display("FAIL load_15: got %0d expected %0d", Q, m_q); end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b1, 1'b1, 4'd4);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    tests_run++;
    if (Q !== 4'd6) begin tests_failed++; $display("FAIL pre_reset_q: got %0d expected 6", Q); end
    #0.5;
    RESET_N = 1'b0;
    #0.5;
    m_q = 0; m_wrap = 0;
    tests_run++;
    if (Q !== 4'd0 || WRAP !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got q=%0d wrap=%b expected q=0 wrap=0", Q, WRAP);
    end
    #2.5;
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      tests_run++;
      if (Q !== 4'(m_q) || Q !== 4'(i + 1)) begin
        tests_failed++;
        $display("FAIL resume[%0d]: got %0d expected %0d", i, Q, i + 1);
      end
    end
  endtask

  task automatic test_saturate_edges();
    cycle(1'b0, 1'b1, 1'b1, 4'd8);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      tests_run++;
      if (Q !== 4'(m_q) || WRAP !== 1'(m_wrap)) begin
        tests_failed++;
        $display("FAIL edge_up[%0d]: got q=%0d wrap=%b expected q=%0d wrap=%0d", i, Q, WRAP, m_q, m_wrap);
      end
    end
    cycle(1'b0, 1'b0, 1'b1, 4'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      tests_run++;
      if (Q !== 4'(m_q) || WRAP !== 1'(m_wrap)) begin
        tests_failed++;
        $display("FAIL edge_down[%0d]: got q=%0d wrap=%b expected q=%0d wrap=%0d", i, Q, WRAP, m_q, m_wrap);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic en, up, ld;
      logic [W-1:0] d;
      en = 1'($urandom_range(0, 3) != 0);
      up = 1'($urandom_range(0, 1));
      ld = 1'($urandom_range(0, 9) == 0);
      d  = 4'($urandom_range(0, 15));
      cycle(en, up, ld, d);
      tests_run++;
      if (Q !== 4'(m_q) || WRAP !== 1'(m_wrap) || TC !== 1'(model_tc())) begin
        tests_failed++;
        $display("FAIL random[%0d]: got q=%0d wrap=%b tc=%b expected q=%0d wrap=%0d tc=%0d",
                 i, Q, WRAP, TC, m_q, m_wrap, model_tc());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clamp();
    test_async_reset();
    test_saturate_edges();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
